path_stack: RTL and testbench
=============================

Name: path_stack

Overview:
- Parametrised LIFO that records turn/direction codes during maze exploration and returns them for backtracking.
- Generalises the earlier fixed 2-bit/50-entry stack:
  - configurable width and depth
  - full/empty/count status
  - simultaneous push+pop as replace-top
  - sticky error flags
  - replay mode that drains the whole stack over a valid/ready handshake to the motion controller
- Sits between the sensor/decision FSM (push/pop commands) and the motor path sequencer (replay consumer).

Parameters:
- DATA_W, 2, width of each stored entry (direction code).
- DEPTH, 50, maximum number of entries.
- CNT_W, $clog2(DEPTH+1), width of the occupancy counter.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- en  input  1  global enable; low freezes storage, count and FSM
- push  input  1  push request level; acted on at rising edge
- push_val  input  DATA_W  entry to push
- pop  input  1  pop request level; acted on at rising edge
- pop_val  output  DATA_W  popped entry, registered
- pop_valid  output  1  one-cycle pulse qualifying pop_val
- replay_start  input  1  rising edge starts drain of the full stack
- rp_val  output  DATA_W  current top during replay
- rp_valid  output  1  replay data valid
- rp_ready  input  1  consumer accepts rp_val
- replay_busy  output  1  high while the replay FSM is in DRAIN
- top_val  output  DATA_W  current top entry; 0 when empty
- count  output  CNT_W  number of stored entries
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- clr_err  input  1  clears sticky error flags (STACK_ERR_EN only)
- overflow  output  1  sticky: push attempted while full
- underflow  output  1  sticky: pop attempted while empty

Behaviour:
- Reset values:
  - count=0; all memory entries=0.
  - pop_val=0, pop_valid=0, rp_valid=0, replay_busy=0.
  - overflow=0, underflow=0.
  - FSM=IDLE; edge-detect registers=0.
- Edge detection:
  - push, pop and replay_start each pass through a registered rising-edge detector.
  - Detectors update every cycle regardless of en, so an edge arriving while en=0 is lost.
- When en=0: no state changes; pop_valid is forced to 0.
- FSM states: IDLE, DRAIN.
- In IDLE with en=1, one cycle after a detected edge:
  - Push only, count<DEPTH: mem[count]<=push_val; count+1.
  - Push only, full: push ignored; overflow<=1.
  - Pop only, count>0: pop_val<=mem[count-1]; pop_valid=1 for one cycle; mem[count-1]<=0; count-1.
  - Pop only, empty: pop_valid stays 0; pop_val unchanged; underflow<=1.
  - Push and pop in the same cycle, count>0 (replace-top):
    - pop_val<=old top; pop_valid=1.
    - mem[count-1]<=push_val; count unchanged.
    - No overflow, even when full.
  - Push and pop in the same cycle, empty: treated as push only; no underflow.
  - replay_start edge with count>0: enter DRAIN. With count=0: ignored. replay_start takes priority over push/pop edges in the same cycle; those edges are dropped.
- Priority: replay_start, then replace-top, then push/pop.
- In DRAIN:
  - replay_busy=1; rp_valid=1; rp_val=top (combinational from mem[count-1]).
  - On rp_valid && rp_ready && en: clear the entry; count-1.
  - When the accepted entry brings count to 0: return to IDLE next cycle; rp_valid=0.
  - Push/pop/replay_start edges in DRAIN are ignored and set no error flags.
  - rp_valid must not drop while rp_ready is low (standard valid/ready hold).
- Outside DRAIN, rp_valid=0 and rp_val=0.
- Status outputs:
  - full, empty and top_val are combinational from count.
  - count never exceeds DEPTH and never wraps below 0.
- Error flags:
  - overflow/underflow stay set until clr_err=1 (synchronous clear) or rst.
  - Set and clear in the same cycle: set wins.
- rst asserted mid-replay aborts DRAIN immediately; all state returns to reset values.

Optional Feature:
- Macro: STACK_ERR_EN.
- Defined: overflow/underflow sticky flags and clr_err behave as above.
- Undefined: overflow and underflow are tied to 0, clr_err is unused, and no error registers are synthesised; push-when-full and pop-when-empty are still silently ignored.

Decomposition:
- Package stack_pkg:
  - enum stack_state_t {IDLE, DRAIN}.
  - Direction code localparams DIR_STRAIGHT=0, DIR_LEFT=1, DIR_RIGHT=2, DIR_BACK=3 (used by DATA_W=2 users).
- Sub-module rise_edge (registered one-pulse detector, async reset), instantiated three times for push, pop and replay_start.

Test Plan:
- Push 1,2,3 (separate level pulses) then pop three times -> pop_val 3,2,1 each with a one-cycle pop_valid; count 3→0; empty=1.
- Hold push high for 5 cycles with push_val=2 -> exactly one entry stored; count=1.
- DEPTH=4: push 5 times -> count=4, full=1, overflow=1. Pop on empty -> underflow=1, pop_valid=0. clr_err -> both flags 0.
- Stack [1,2]; push=3 and pop in the same cycle -> pop_val=2, pop_valid=1; top_val=3; count=2.
- Stack [0,1,2]; replay_start; rp_ready low for 2 cycles then high -> rp_val held at 2, then 2,1,0 accepted; replay_busy falls; count=0. A push edge during DRAIN leaves count unaffected.
- Assert rst after one replay handshake -> count=0, rp_valid=0, FSM=IDLE on the next clock.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared types and constants for the path_stack LIFO.
// The replay FSM state enum lives here, together with the direction codes
// the maze explorer stores when DATA_W=2.
package stack_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } stack_state_t;

  localparam logic [1:0] DIR_STRAIGHT = 2'd0;
  localparam logic [1:0] DIR_LEFT     = 2'd1;
  localparam logic [1:0] DIR_RIGHT    = 2'd2;
  localparam logic [1:0] DIR_BACK     = 2'd3;

endpackage

// File: rtl/rise_edge.sv
// Registered rising-edge detector: the pulse output is high for exactly one
// cycle, one clock after the input was first seen high. Runs independently
// of any enable so an edge that arrives while the consumer is frozen is lost.
module rise_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic d_q;
  logic pulse_q;

  // Remember the previous input level and register the 0->1 transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q     <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      d_q     <= d;
      pulse_q <= d & ~d_q;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/path_stack.sv
// path_stack: parametrised LIFO of direction codes for maze backtracking.
// Push/pop commands are edge-triggered; a simultaneous push+pop replaces the
// top entry. A replay FSM (IDLE/DRAIN) empties the whole stack top-first to
// the motion sequencer.
// Replay handshake: rp_val is transferred on every rising clk edge where
// rp_valid && rp_ready && en; rp_valid stays high and rp_val stable until the
// transfer happens.
// Optional build macro STACK_ERR_EN: enables the sticky overflow/underflow
// flags and clr_err; without it both flags read 0 and no flag registers exist.
import stack_pkg::*;

module path_stack #(
  parameter int DATA_W = 2,
  parameter int DEPTH  = 50,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              push,
  input  logic [DATA_W-1:0] push_val,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_val,
  output logic              pop_valid,
  input  logic              replay_start,
  output logic [DATA_W-1:0] rp_val,
  output logic              rp_valid,
  input  logic              rp_ready,
  output logic              replay_busy,
  output logic [DATA_W-1:0] top_val,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  input  logic              clr_err,
  output logic              overflow,
  output logic              underflow,
  output logic              state_dbg
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  stack_state_t      state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] pop_val_q, pop_val_d;
  logic              pop_valid_q, pop_valid_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              push_p, pop_p, rs_p;
  logic              full_w, empty_w;
  logic [AW-1:0]     top_idx;
  logic              mem_we;
  logic [AW-1:0]     wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic              ovf_set, udf_set;

  rise_edge u_push_edge (.clk(clk), .rst(rst), .d(push),         .pulse(push_p));
  rise_edge u_pop_edge  (.clk(clk), .rst(rst), .d(pop),          .pulse(pop_p));
  rise_edge u_rs_edge   (.clk(clk), .rst(rst), .d(replay_start), .pulse(rs_p));

  assign full_w  = (count_q == DEPTH_C);
  assign empty_w = (count_q == '0);
  // Only meaningful when count_q > 0; every use below is qualified by that.
  assign top_idx = AW'(count_q - ONE_C);

  // Next-state decode: replay start first, then replace-top, then push/pop.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    pop_val_d   = pop_val_q;
    pop_valid_d = 1'b0;
    mem_we      = 1'b0;
    wr_idx      = top_idx;
    wr_data     = '0;
    ovf_set     = 1'b0;
    udf_set     = 1'b0;
    if (en) begin
      unique case (state_q)
        IDLE: begin
          if (rs_p && !empty_w) begin
            state_d = DRAIN;
          end else if (push_p && pop_p && !empty_w) begin
            pop_val_d   = mem_q[top_idx];
            pop_valid_d = 1'b1;
            mem_we      = 1'b1;
            wr_data     = push_val;
          end else if (push_p) begin
            if (!full_w) begin
              mem_we  = 1'b1;
              wr_idx  = AW'(count_q);
              wr_data = push_val;
              count_d = count_q + ONE_C;
            end else begin
              ovf_set = 1'b1;
            end
          end else if (pop_p) begin
            if (!empty_w) begin
              pop_val_d   = mem_q[top_idx];
              pop_valid_d = 1'b1;
              mem_we      = 1'b1;
              count_d     = count_q - ONE_C;
            end else begin
              udf_set = 1'b1;
            end
          end
        end
        DRAIN: begin
          if (rp_ready) begin
            mem_we  = 1'b1;
            count_d = count_q - ONE_C;
            if (count_q == ONE_C) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM state and occupancy; frozen while en is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
    end else if (en) begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Registered pop result; the valid pulse never survives a frozen cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pop_val_q   <= '0;
      pop_valid_q <= 1'b0;
    end else if (en) begin
      pop_val_q   <= pop_val_d;
      pop_valid_q <= pop_valid_d;
    end else begin
      pop_valid_q <= 1'b0;
    end
  end

  // Storage: a single write port covers push, replace and clearing on pop/drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

`ifdef STACK_ERR_EN
  logic ovf_q, udf_q;

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (ovf_set)            ovf_q <= 1'b1;
      else if (clr_err && en) ovf_q <= 1'b0;
      if (udf_set)            udf_q <= 1'b1;
      else if (clr_err && en) udf_q <= 1'b0;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = udf_q;
`else
  logic unused_err;
  assign unused_err = clr_err ^ ovf_set ^ udf_set;
  assign overflow   = 1'b0;
  assign underflow  = 1'b0;
`endif

  assign count       = count_q;
  assign full        = full_w;
  assign empty       = empty_w;
  assign top_val     = empty_w ? '0 : mem_q[top_idx];
  assign pop_val     = pop_val_q;
  assign pop_valid   = pop_valid_q & en;
  assign replay_busy = (state_q == DRAIN);
  assign rp_valid    = (state_q == DRAIN);
  assign rp_val      = (state_q == DRAIN) ? mem_q[top_idx] : '0;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_path_stack.sv
// Testbench for path_stack (DEPTH=4, DATA_W=2): directed vector table,
// replay/reset sequences, then random ops against a queue-based model.
module tb_path_stack;

`ifdef STACK_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst, en, push, pop, replay_start, rp_ready, clr_err;
  logic [1:0] push_val, pop_val, rp_val, top_val;
  logic       pop_valid, rp_valid, replay_busy, full, empty;
  logic       overflow, underflow, state_dbg;
  logic [2:0] count;

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0] pop_got[$];
  logic [1:0] rp_got[$];
  logic [1:0] exp_q[$];
  logic [1:0] mq[$];
  bit         m_ovf, m_udf;

  typedef struct {
    bit p; bit q; bit c; logic [1:0] v;
    int cnt; int top; int npv; int pval; bit ovf; bit udf;
  } vec_t;
  vec_t tbl[$];

  path_stack #(.DATA_W(2), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .en(en), .push(push), .push_val(push_val),
    .pop(pop), .pop_val(pop_val), .pop_valid(pop_valid),
    .replay_start(replay_start), .rp_val(rp_val), .rp_valid(rp_valid),
    .rp_ready(rp_ready), .replay_busy(replay_busy), .top_val(top_val),
    .count(count), .full(full), .empty(empty), .clr_err(clr_err),
    .overflow(overflow), .underflow(underflow), .state_dbg(state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // Monitors sample on the falling edge
  always @(negedge clk) begin
    if (pop_valid) pop_got.push_back(pop_val);
    if (rp_valid && rp_ready) rp_got.push_back(rp_val);
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_op(input bit p, input bit q, input bit c, input logic [1:0] v);
    @(posedge clk); #1;
    push = p; pop = q; clr_err = c; push_val = v;
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0; clr_err = 1'b0;
    step(2);
  endtask

  task automatic chk_status(input string nm, input int c, input int t, input bit o, input bit u);
    chk({nm, "_count"}, int'(count), c);
    chk({nm, "_top"}, int'(top_val), t);
    chk({nm, "_full"}, int'(full), int'(c == DEPTH));
    chk({nm, "_empty"}, int'(empty), int'(c == 0));
    chk({nm, "_ovf"}, int'(overflow), int'(o & ERR_EN));
    chk({nm, "_udf"}, int'(underflow), int'(u & ERR_EN));
  endtask

  task automatic chk_pops(input string nm, input int npv, input int pval);
    chk({nm, "_npop"}, pop_got.size(), npv);
    if (npv == 1 && pop_got.size() == 1) chk({nm, "_popval"}, int'(pop_got[0]), pval);
  endtask

  // Start a replay and drain with random (mode 0) or constant (mode 1) ready.
  task automatic do_replay(input int mode);
    int cycles;
    int viol;
    bit prev_v, prev_r;
    rp_got.delete();
    @(posedge clk); #1 replay_start = 1'b1;
    @(posedge clk); #1 replay_start = 1'b0;
    step(1);
    cycles = 0; viol = 0; prev_v = 1'b0; prev_r = 1'b0;
    while (replay_busy && cycles < 200) begin
      if (prev_v && !prev_r && !rp_valid) viol++;
      rp_ready = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      prev_v = rp_valid; prev_r = rp_ready;
      @(posedge clk); #1;
      cycles++;
    end
    rp_ready = 1'b0;
    chk("drain_timeout", int'(cycles >= 200), 0);
    chk("rp_hold", viol, 0);
    chk("drain_len", rp_got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rp_got.size(); i++)
      chk("drain_val", int'(rp_got[i]), int'(exp_q[i]));
    chk("drain_rp_valid", int'(rp_valid), 0);
    chk("drain_rp_val", int'(rp_val), 0);
  endtask

  initial begin
    int npv, pval, kind;
    logic [1:0] v;
    rst = 1'b1; en = 1'b1; push = 1'b0; pop = 1'b0; replay_start = 1'b0;
    rp_ready = 1'b0; clr_err = 1'b0; push_val = 2'd0;

    // Reset values
    step(3);
    chk_status("rst", 0, 0, 1'b0, 1'b0);
    chk("rst_pop_valid", int'(pop_valid), 0);
    chk("rst_pop_val", int'(pop_val), 0);
    chk("rst_rp_valid", int'(rp_valid), 0);
    chk("rst_busy", int'(replay_busy), 0);
    chk("rst_state", int'(state_dbg), 0);
    rst = 1'b0;
    step(2);

    // push, pop, clr, val | count, top, n_pop, pop_val, ovf, udf
    tbl.push_back('{1,0,0,2'd1, 1,1,0,0,0,0});
    tbl.push_back('{1,0,0,2'd2, 2,2,0,0,0,0});
    tbl.push_back('{1,0,0,2'd3, 3,3,0,0,0,0});
    tbl.push_back('{0,1,0,2'd0, 2,2,1,3,0,0});
    tbl.push_back('{0,1,0,2'd0, 1,1,1,2,0,0});
    tbl.push_back('{0,1,0,2'd0, 0,0,1,1,0,0});
    tbl.push_back('{0,1,0,2'd0, 0,0,0,0,0,1});
    tbl.push_back('{1,1,0,2'd2, 1,2,0,0,0,1});
    tbl.push_back('{0,0,1,2'd0, 1,2,0,0,0,0});
    tbl.push_back('{0,1,0,2'd0, 0,0,1,2,0,0});
    tbl.push_back('{1,0,0,2'd1, 1,1,0,0,0,0});
    tbl.push_back('{1,0,0,2'd2, 2,2,0,0,0,0});
    tbl.push_back('{1,1,0,2'd3, 2,3,1,2,0,0});
    tbl.push_back('{1,0,0,2'd0, 3,0,0,0,0,0});
    tbl.push_back('{1,0,0,2'd1, 4,1,0,0,0,0});
    tbl.push_back('{1,0,0,2'd2, 4,1,0,0,1,0});
    tbl.push_back('{1,1,0,2'd3, 4,3,1,1,1,0});
    tbl.push_back('{0,0,1,2'd0, 4,3,0,0,0,0});
    tbl.push_back('{0,1,0,2'd0, 3,0,1,3,0,0});
    tbl.push_back('{0,1,0,2'd0, 2,3,1,0,0,0});
    tbl.push_back('{0,1,0,2'd0, 1,1,1,3,0,0});
    tbl.push_back('{0,1,0,2'd0, 0,0,1,1,0,0});
    foreach (tbl[i]) begin
      pop_got.delete();
      do_op(tbl[i].p, tbl[i].q, tbl[i].c, tbl[i].v);
      chk_status($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].top, tbl[i].ovf, tbl[i].udf);
      chk_pops($sformatf("vec%0d", i), tbl[i].npv, tbl[i].pval);
    end

    // Level held high for 5 cycles stores a single entry
    push_val = 2'd2;
    @(posedge clk); #1 push = 1'b1;
    repeat (5) @(posedge clk);
    #1 push = 1'b0;
    step(2);
    chk_status("hold", 1, 2, 1'b0, 1'b0);
    pop_got.delete();
    do_op(0, 1, 0, 2'd0);
    chk_pops("hold_pop", 1, 2);

    // Edge seen while en=0 is lost
    @(posedge clk); #1 en = 1'b0; push = 1'b1; push_val = 2'd3;
    @(posedge clk); #1 push = 1'b0;
    @(posedge clk); #1 en = 1'b1;
    step(2);
    chk_status("en_low", 0, 0, 1'b0, 1'b0);

    // Replay [0,1,2] with ready held low, push edge during DRAIN ignored
    do_op(1, 0, 0, 2'd0);
    do_op(1, 0, 0, 2'd1);
    do_op(1, 0, 0, 2'd2);
    rp_got.delete();
    rp_ready = 1'b0;
    @(posedge clk); #1 replay_start = 1'b1;
    @(posedge clk); #1 replay_start = 1'b0;
    step(1);
    chk("rp_busy", int'(replay_busy), 1);
    chk("rp_valid_wait", int'(rp_valid), 1);
    chk("rp_val_wait", int'(rp_val), 2);
    do_op(1, 0, 0, 2'd3);
    chk("rp_val_held", int'(rp_val), 2);
    chk("rp_valid_held", int'(rp_valid), 1);
    chk_status("drain_push", 3, 2, 1'b0, 1'b0);
    exp_q = '{2'd2, 2'd1, 2'd0};
    begin
      int cyc;
      cyc = 0;
      rp_ready = 1'b1;
      while (replay_busy && cyc < 50) begin
        step(1);
        cyc++;
      end
      rp_ready = 1'b0;
      chk("dir_drain_timeout", int'(cyc >= 50), 0);
    end
    chk("dir_drain_len", rp_got.size(), 3);
    for (int i = 0; i < 3 && i < rp_got.size(); i++)
      chk("dir_drain_val", int'(rp_got[i]), int'(exp_q[i]));
    chk_status("dir_drain_end", 0, 0, 1'b0, 1'b0);
    chk("dir_rp_valid_end", int'(rp_valid), 0);

    // Reset after one replay handshake
    do_op(1, 0, 0, 2'd3);
    do_op(1, 0, 0, 2'd1);
    rp_got.delete();
    @(posedge clk); #1 replay_start = 1'b1;
    @(posedge clk); #1 replay_start = 1'b0;
    step(1);
    rp_ready = 1'b1;
    step(1);
    rp_ready = 1'b0;
    chk("mid_accepts", rp_got.size(), 1);
    chk("mid_count", int'(count), 1);
    rst = 1'b1;
    step(1);
    chk("rst_mid_count", int'(count), 0);
    chk("rst_mid_rp_valid", int'(rp_valid), 0);
    chk("rst_mid_busy", int'(replay_busy), 0);
    chk("rst_mid_state", int'(state_dbg), 0);
    chk("rst_mid_top", int'(top_val), 0);
    rst = 1'b0;
    step(2);

    // Random ops vs queue model
    mq.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    for (int it = 0; it < 150; it++) begin
      kind = $urandom_range(0, 9);
      v = 2'($urandom_range(0, 3));
      if (kind == 9) begin
        exp_q.delete();
        for (int i = mq.size() - 1; i >= 0; i--) exp_q.push_back(mq[i]);
        mq.delete();
        do_replay($urandom_range(0, 1));
      end else begin
        npv = 0; pval = 0;
        if (kind == 8) begin
          m_ovf = 1'b0; m_udf = 1'b0;
        end else if (kind == 7 && mq.size() > 0) begin
          npv = 1; pval = mq[$]; mq[mq.size() - 1] = v;
        end else if (kind <= 3 || kind == 7) begin
          if (mq.size() < DEPTH) mq.push_back(v);
          else m_ovf = 1'b1;
        end else begin
          if (mq.size() > 0) begin npv = 1; pval = mq.pop_back(); end
          else m_udf = 1'b1;
        end
        pop_got.delete();
        do_op(kind <= 3 || kind == 7, kind >= 4 && kind <= 7, kind == 8, v);
        chk_pops("rnd", npv, pval);
      end
      chk_status("rnd", mq.size(), (mq.size() > 0) ? int'(mq[$]) : 0, m_ovf, m_udf);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
